// File: rtl/riscv_hazard_pkg.sv
// Shared encodings for the pipeline hazard controller: forward-mux selects and FSM states.
package riscv_hazard_pkg;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } hz_state_t;

endpackage

// File: rtl/fwd_select.sv
// Forward-select for one E-stage operand: the youngest in-flight writer of rs wins, x0 is never forwarded.
module fwd_select
    import riscv_hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        fwd
);

    always_comb begin
        fwd = FWD_RD;
        if (reg_write_m && (rd_m == rs) && (rs != '0)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (rd_w == rs) && (rs != '0)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use stall, branch flush,
// multi-cycle execute sequencing and saturating stall/flush profiling counters.
module hazard_ctrl
    import riscv_hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int CNT_W   = 32,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] Rd_E,
    input  logic [REG_AW-1:0] Rd_M,
    input  logic [REG_AW-1:0] Rd_W,
    input  logic              RegWrite_M,
    input  logic              RegWrite_W,
    input  logic              Load_E,
    input  logic              PCSrc_E,
    input  logic              MulStart_E,
    output logic [1:0]        ForwardA_E,
    output logic [1:0]        ForwardB_E,
    output logic              Stall_F,
    output logic              Stall_D,
    output logic              Stall_E,
    output logic              Flush_D,
    output logic              Flush_E,
    output logic              Flush_M,
    output logic              busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    localparam int             CW       = $clog2(MUL_LAT) + 1;
    localparam bit             MULTI    = (MUL_LAT > 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    hz_state_t      state;
    hz_state_t      state_next;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_next;
    logic           mul_stall;
    logic           lw_stall;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .rs          (Rs1_E),
        .rd_m        (Rd_M),
        .rd_w        (Rd_W),
        .reg_write_m (RegWrite_M),
        .reg_write_w (RegWrite_W),
        .fwd         (ForwardA_E)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .rs          (Rs2_E),
        .rd_m        (Rd_M),
        .rd_w        (Rd_W),
        .reg_write_m (RegWrite_M),
        .reg_write_w (RegWrite_W),
        .fwd         (ForwardB_E)
    );

    assign lw_stall = Load_E && (Rd_E != '0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The cycle that accepts the op is the first stalled cycle, so BUSY only counts the remainder.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mul_stall  = 1'b0;
        case (state)
            IDLE: begin
                if (MulStart_E && MULTI) begin
                    mul_stall  = 1'b1;
                    cnt_next   = CNT_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    mul_stall = 1'b1;
                    cnt_next  = cnt - CW'(1);
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Controls are forced low while reset is held so the pipeline is released immediately.
    assign Stall_F = rst_n && (lw_stall || mul_stall);
    assign Stall_D = rst_n && (lw_stall || mul_stall);
    assign Stall_E = rst_n && mul_stall;
    assign Flush_M = rst_n && mul_stall;
    assign Flush_E = rst_n && (lw_stall || PCSrc_E);
    assign Flush_D = rst_n && PCSrc_E;
    assign busy    = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (Stall_F && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (PCSrc_E && (flush_events != '1)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three instances (MUL_LAT 4/1/2, narrow counters on two)
// driven by shared directed and random stimulus, checked against an occupancy-based model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
    logic       RegWrite_M, RegWrite_W, Load_E, PCSrc_E, MulStart_E;

    logic [1:0]  fa [3];
    logic [1:0]  fb [3];
    logic        sf [3];
    logic        sd [3];
    logic        se [3];
    logic        fd [3];
    logic        fe [3];
    logic        fm [3];
    logic        bz [3];
    logic [31:0] sc0, fl0;
    logic [2:0]  sc1, fl1;
    logic [3:0]  sc2, fl2;

    typedef struct {
        logic [2:0][10:0] flags;
        logic [2:0][31:0] sc;
        logic [2:0][31:0] fl;
    } exp_t;

    exp_t sb [$];

    int     tests = 0;
    int     fails = 0;
    int     lat  [3] = '{4, 1, 2};
    longint cmax [3] = '{64'hFFFF_FFFF, 7, 15};
    int     occ  [3];
    longint nst  [3];
    longint nfl  [3];

    always #5 clk = ~clk;

    hazard_ctrl #(.MUL_LAT(4), .CNT_W(32), .REG_AW(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .MulStart_E(MulStart_E),
        .ForwardA_E(fa[0]), .ForwardB_E(fb[0]), .Stall_F(sf[0]), .Stall_D(sd[0]), .Stall_E(se[0]),
        .Flush_D(fd[0]), .Flush_E(fe[0]), .Flush_M(fm[0]), .busy(bz[0]),
        .stall_cycles(sc0), .flush_events(fl0)
    );

    hazard_ctrl #(.MUL_LAT(1), .CNT_W(3), .REG_AW(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .MulStart_E(MulStart_E),
        .ForwardA_E(fa[1]), .ForwardB_E(fb[1]), .Stall_F(sf[1]), .Stall_D(sd[1]), .Stall_E(se[1]),
        .Flush_D(fd[1]), .Flush_E(fe[1]), .Flush_M(fm[1]), .busy(bz[1]),
        .stall_cycles(sc1), .flush_events(fl1)
    );

    hazard_ctrl #(.MUL_LAT(2), .CNT_W(4), .REG_AW(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .Rd_E(Rd_E), .Rd_M(Rd_M), .Rd_W(Rd_W), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
        .Load_E(Load_E), .PCSrc_E(PCSrc_E), .MulStart_E(MulStart_E),
        .ForwardA_E(fa[2]), .ForwardB_E(fb[2]), .Stall_F(sf[2]), .Stall_D(sd[2]), .Stall_E(se[2]),
        .Flush_D(fd[2]), .Flush_E(fe[2]), .Flush_M(fm[2]), .busy(bz[2]),
        .stall_cycles(sc2), .flush_events(fl2)
    );

    function automatic logic [1:0] fwdModel(input logic [4:0] rs, input logic [4:0] rdm,
                                            input logic [4:0] rdw, input logic rwm, input logic rww);
        if (rs == 5'd0)               return 2'b00;
        if (rwm && rdm == rs)         return 2'b10;
        if (rww && rdw == rs)         return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] satModel(input longint n, input longint mx);
        return 32'((n > mx) ? mx : n);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        for (int d = 0; d < 3; d++) begin
            occ[d] = 0;
            nst[d] = 0;
            nfl[d] = 0;
        end
    endtask

    // Each op occupies E for lat cycles: stalled for the first lat-1, busy from the second on.
    task automatic applyStimulus(input logic [4:0] r1d, input logic [4:0] r2d, input logic [4:0] r1e,
                                 input logic [4:0] r2e, input logic [4:0] rde, input logic [4:0] rdm,
                                 input logic [4:0] rdw, input logic rwm, input logic rww,
                                 input logic ld, input logic pc, input logic ms);
        exp_t       e;
        logic       lw, mstall, bsy, stf;
        logic [1:0] ea, eb;
        int         age;
        @(negedge clk);
        Rs1_D = r1d; Rs2_D = r2d; Rs1_E = r1e; Rs2_E = r2e; Rd_E = rde; Rd_M = rdm; Rd_W = rdw;
        RegWrite_M = rwm; RegWrite_W = rww; Load_E = ld; PCSrc_E = pc; MulStart_E = ms;
        lw = ld && (rde != 0) && (rde == r1d || rde == r2d);
        ea = fwdModel(r1e, rdm, rdw, rwm, rww);
        eb = fwdModel(r2e, rdm, rdw, rwm, rww);
        for (int d = 0; d < 3; d++) begin
            age    = (occ[d] == 0 && ms) ? 1 : occ[d];
            mstall = (age >= 1) && (age <= lat[d] - 1);
            bsy    = (age >= 2);
            stf    = lw || mstall;
            e.flags[d] = {ea, eb, stf, stf, mstall, pc, lw || pc, mstall, bsy};
            e.sc[d]    = satModel(nst[d], cmax[d]);
            e.fl[d]    = satModel(nfl[d], cmax[d]);
            nst[d] += longint'(stf);
            nfl[d] += longint'(pc);
            occ[d] = (age == 0 || age >= lat[d]) ? 0 : age + 1;
        end
        sb.push_back(e);
    endtask

    task automatic idleCycle(input logic ms);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, ms);
    endtask

    task automatic checkReset();
        checkOutput("rst_ctl0", {25'd0, sf[0], sd[0], se[0], fd[0], fe[0], fm[0], bz[0]}, 32'd0);
        checkOutput("rst_ctl1", {25'd0, sf[1], sd[1], se[1], fd[1], fe[1], fm[1], bz[1]}, 32'd0);
        checkOutput("rst_ctl2", {25'd0, sf[2], sd[2], se[2], fd[2], fe[2], fm[2], bz[2]}, 32'd0);
        checkOutput("rst_stall_cycles0", sc0, 32'd0);
        checkOutput("rst_flush_events0", fl0, 32'd0);
        checkOutput("rst_stall_cycles2", 32'(sc2), 32'd0);
    endtask

    // Monitor: one output set per cycle, compared against the oldest pending expectation.
    initial begin
        exp_t         e;
        logic [31:0]  asc [3];
        logic [31:0]  afl [3];
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                asc[0] = sc0;        afl[0] = fl0;
                asc[1] = 32'(sc1);   afl[1] = 32'(fl1);
                asc[2] = 32'(sc2);   afl[2] = 32'(fl2);
                for (int d = 0; d < 3; d++) begin
                    checkOutput($sformatf("flags_dut%0d", d),
                                {21'd0, fa[d], fb[d], sf[d], sd[d], se[d], fd[d], fe[d], fm[d], bz[d]},
                                {21'd0, e.flags[d]});
                    checkOutput($sformatf("stall_cycles_dut%0d", d), asc[d], e.sc[d]);
                    checkOutput($sformatf("flush_events_dut%0d", d), afl[d], e.fl[d]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; Rd_E = 0; Rd_M = 0; Rd_W = 0;
        RegWrite_M = 0; RegWrite_W = 0; Load_E = 0; PCSrc_E = 0; MulStart_E = 0;
        resetModel();
        #2;
        checkReset();
        #5;
        rst_n = 1'b1;

        // forwarding: M beats W, x0 never forwarded
        applyStimulus(0, 0, 5, 6, 0, 5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(0, 0, 0, 3, 0, 0, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // load-use then branch
        applyStimulus(0, 7, 0, 0, 7, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycle(1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        idleCycle(1'b0);
        // one multi-cycle op held until release, then back-to-back
        repeat (4) idleCycle(1'b1);
        repeat (2) idleCycle(1'b0);
        repeat (8) idleCycle(1'b1);
        repeat (2) idleCycle(1'b0);

        // reset during BUSY with cnt==1 on the MUL_LAT=4 instance
        repeat (3) idleCycle(1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        checkReset();
        resetModel();
        #3;
        rst_n = 1'b1;
        repeat (3) idleCycle(1'b0);

        for (int i = 0; i < 600; i++) begin
            logic ld, pc;
            ld = ($urandom_range(0, 3) == 0);
            pc = !ld && ($urandom_range(0, 4) == 0);
            applyStimulus(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), ld, pc, ($urandom_range(0, 2) == 0));
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #4;
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
